// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin bus arbiter with active-low request/grant lines.
// Optional hold-limit preemption is compiled in when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_params
    $error("bus_arbiter: illegal HOLD_MAX/CNT_W combination");
  end

  logic [3:0] req;
  logic [1:0] owner_next;
  logic [1:0] next_req_idx;
  logic       next_req_found;
  logic       owner_req;

  assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign owner_req = req[owner];

  // Rotating search from owner+1; descending loop lets the nearest requester win.
  always_comb begin
    next_req_found = 1'b0;
    next_req_idx   = owner;
    for (int i = 3; i >= 1; i--) begin
      if (req[owner + 2'(i)]) begin
        next_req_found = 1'b1;
        next_req_idx   = owner + 2'(i);
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_next;
  logic             others_wait;
  logic             hold_expired;

  assign others_wait  = |(req & ~(4'b0001 << owner));
  assign hold_expired = (hold_cnt == CNT_W'(HOLD_MAX - 1));

  // Counter only runs while the owner holds and someone else is waiting.
  always_comb begin
    owner_next    = owner;
    hold_cnt_next = '0;
    if (owner_req && others_wait) begin
      if (hold_expired) begin
        owner_next = next_req_idx;
      end else begin
        hold_cnt_next = hold_cnt + 1'b1;
      end
    end else if (!owner_req && next_req_found) begin
      owner_next = next_req_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= 2'd0;
      hold_cnt <= '0;
    end else begin
      owner    <= owner_next;
      hold_cnt <= hold_cnt_next;
    end
  end
`else
  always_comb begin
    owner_next = owner;
    if (!owner_req && next_req_found) begin
      owner_next = next_req_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= 2'd0;
    end else begin
      owner <= owner_next;
    end
  end
`endif

  // Grants decode straight from the owner register, so exactly one is low.
  assign m0_grnt_ = (owner != 2'd0);
  assign m1_grnt_ = (owner != 2'd1);
  assign m2_grnt_ = (owner != 2'd2);
  assign m3_grnt_ = (owner != 2'd3);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed-vector bench for bus_arbiter with hand-computed owners.
// Covers reset, rotation, wrap, parking, hold, mid-transfer reset and hold-limit behaviour.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic [3:0] grnt;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;

  bus_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(m0_req_), .m1_req_(m1_req_), .m2_req_(m2_req_), .m3_req_(m3_req_),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
    .owner(owner)
  );

  always #5 clk = ~clk;

  assign grnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // req_n is {m3,m2,m1,m0} active-low; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] req_n);
    reset = rst;
    {m3_req_, m2_req_, m1_req_, m0_req_} = req_n;
    @(posedge clk);
    #1;
  endtask

  task automatic expectOwner(input string tag, input logic [1:0] exp_owner);
    logic [3:0] exp_grnt;
    exp_grnt = ~(4'b0001 << exp_owner);
    checkOutput({tag, "_owner"}, 32'(owner), 32'(exp_owner));
    checkOutput({tag, "_grnt"}, 32'(grnt), 32'(exp_grnt));
  endtask

  // Every cycle: exactly one grant low, and it belongs to the reported owner.
  always @(negedge clk) begin
    logic [3:0] dec;
    if (mon_en) begin
      dec = ~(4'b0001 << owner);
      checkOutput("one_grant_low", 32'($countones(~grnt)), 32'd1);
      checkOutput("grant_matches_owner", 32'(grnt), 32'(dec));
    end
  end

  initial begin
    reset = 1'b1;
    {m3_req_, m2_req_, m1_req_, m0_req_} = 4'b1111;

    // Reset held two cycles, then parks on master 0.
    applyStimulus(1'b1, 4'b1111);
    applyStimulus(1'b1, 4'b1111);
    expectOwner("reset", 2'd0);
    mon_en = 1'b1;
    applyStimulus(1'b0, 4'b1111);
    expectOwner("park_after_reset", 2'd0);

    // m1 and m2 request: m1 is nearest after owner 0.
    applyStimulus(1'b0, 4'b1001);
    expectOwner("rr_to_m1", 2'd1);

    // m1 releases with m0 and m2 waiting: rotation picks m2, not m0.
    applyStimulus(1'b0, 4'b1010);
    expectOwner("rr_to_m2", 2'd2);

    // m2 releases, m3 requests.
    applyStimulus(1'b0, 4'b0111);
    expectOwner("rr_to_m3", 2'd3);

    // m3 releases, only m0 waiting: index wraps.
    applyStimulus(1'b0, 4'b1110);
    expectOwner("wrap_to_m0", 2'd0);

    // m0 releases, m2 requests, then everyone releases: bus parks on m2.
    applyStimulus(1'b0, 4'b1011);
    expectOwner("to_m2", 2'd2);
    applyStimulus(1'b0, 4'b1111);
    expectOwner("park_m2_a", 2'd2);
    applyStimulus(1'b0, 4'b1111);
    expectOwner("park_m2_b", 2'd2);
    applyStimulus(1'b0, 4'b0111);
    expectOwner("park_to_m3", 2'd3);

    // m3 holds while m0 waits: ownership kept for one cycle.
    applyStimulus(1'b0, 4'b0110);
    expectOwner("hold_m3", 2'd3);

    // Reset mid-transfer overrides requests.
    applyStimulus(1'b1, 4'b0110);
    expectOwner("reset_mid_xfer", 2'd0);

    // m0 holds alone, then m1 starts waiting.
    applyStimulus(1'b0, 4'b1110);
    expectOwner("m0_hold_alone", 2'd0);
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 4'b1100);
      expectOwner("timeout_pending", 2'd0);
    end
    applyStimulus(1'b0, 4'b1100);
    expectOwner("timeout_handoff", 2'd1);
`else
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 4'b1100);
      expectOwner("no_timeout_hold", 2'd0);
    end
`endif

    // Release everyone; bus parks on the current owner.
    applyStimulus(1'b0, 4'b1111);
`ifdef BUS_ARB_TIMEOUT_EN
    expectOwner("final_park", 2'd1);
`else
    expectOwner("final_park", 2'd0);
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
